// File: rtl/fir_pkg.sv
// fir_pkg: shared FSM state type and accumulator sizing for the FIR sequencer
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Full-precision products plus log2(TAPS) guard bits so the sum of TAPS products never wraps
    function automatic int acc_width(input int dw, input int taps);
        return 2 * dw + $clog2(taps);
    endfunction

endpackage

// File: rtl/fir_mac_slice.sv
// fir_mac_slice: single-multiplier accumulate, Q-format rescale and saturation to the output width
module fir_mac_slice #(
    parameter int DW = 13,
    parameter int AW = 29
) (
    input  logic                 CLK,
    input  logic                 RST_n,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 last,
    input  logic signed [DW-1:0] xin,
    input  logic signed [DW-1:0] hin,
    output logic signed [DW-1:0] dout
);

    logic signed [2*DW-1:0] prod;
    logic signed [AW-1:0]   sum;
    logic signed [AW-1:0]   shifted;
    logic signed [AW-1:0]   acc;
    logic signed [DW-1:0]   sat;
    logic                   fits;

    // Running sum including this cycle's product, floored back to Q1.(DW-1) and clamped
    always_comb begin
        prod    = xin * hin;
        sum     = acc + AW'(prod);
        shifted = sum >>> (DW - 1);
        fits    = (&shifted[AW-1:DW-1]) || !(|shifted[AW-1:DW-1]);
        sat     = fits ? shifted[DW-1:0] : {shifted[AW-1], {(DW-1){!shifted[AW-1]}}};
    end

    // Accumulator: cleared when a sample is accepted, advanced once per MAC cycle
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= sum;
    end

    // Output register: loaded only on the final tap, otherwise holds the last result
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n)
            dout <= '0;
        else if (en && last)
            dout <= sat;
    end

endmodule

// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: sequential FIR filter, one tap per cycle, with coefficient RAM, flush and output handshake
module fir_seq_ctrl
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = 13,
    parameter int TAPS       = 8
) (
    input  logic                          CLK,
    input  logic                          RST_n,
    input  logic signed [DATA_WIDTH-1:0]  DIN,
    input  logic                          DIN_VALID,
    output logic                          DIN_READY,
    input  logic                          COEF_WE,
    input  logic [$clog2(TAPS)-1:0]       COEF_ADDR,
    input  logic signed [DATA_WIDTH-1:0]  COEF_DATA,
    input  logic                          FLUSH,
    output logic signed [DATA_WIDTH-1:0]  DOUT,
    output logic                          DOUT_VALID,
    input  logic                          DOUT_READY,
    output logic                          BUSY
);

    localparam int KW = $clog2(TAPS);
    localparam int AW = acc_width(DATA_WIDTH, TAPS);

    state_t                        state;
    state_t                        nstate;
    logic [KW-1:0]                 k;
    logic signed [DATA_WIDTH-1:0]  x [TAPS];
    logic signed [DATA_WIDTH-1:0]  h [TAPS];
    logic                          idle;
    logic                          accept;
    logic                          in_mac;
    logic                          last;

    assign idle       = (state == IDLE);
    assign in_mac     = (state == MAC);
    assign DIN_READY  = idle && !FLUSH;
    assign accept     = DIN_VALID && DIN_READY;
    assign last       = in_mac && (k == KW'(TAPS - 1));
    assign DOUT_VALID = (state == OUT);
    assign BUSY       = !idle;

    // Next-state: accept -> MAC for TAPS cycles -> OUT until downstream takes the result
    always_comb begin
        nstate = state;
        case (state)
            IDLE:    nstate = accept ? MAC : IDLE;
            MAC:     nstate = last ? OUT : MAC;
            OUT:     nstate = DOUT_READY ? IDLE : OUT;
            default: nstate = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n)
            state <= IDLE;
        else
            state <= nstate;
    end

    // Tap counter selects which x/h pair feeds the multiplier
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n)
            k <= '0;
        else if (accept)
            k <= '0;
        else if (in_mac)
            k <= k + KW'(1);
    end

    // Delay line: flush wins over a new sample and only acts while idle
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int i = 0; i < TAPS; i++) x[i] <= '0;
        end else if (idle && FLUSH) begin
            for (int i = 0; i < TAPS; i++) x[i] <= '0;
        end else if (accept) begin
            x[0] <= DIN;
            for (int i = 1; i < TAPS; i++) x[i] <= x[i-1];
        end
    end

    // Coefficients are writable only while idle; addresses past the last tap match nothing
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int i = 0; i < TAPS; i++) h[i] <= '0;
        end else if (idle && COEF_WE) begin
            for (int i = 0; i < TAPS; i++)
                if (COEF_ADDR == KW'(i)) h[i] <= COEF_DATA;
        end
    end

    fir_mac_slice #(
        .DW (DATA_WIDTH),
        .AW (AW)
    ) u_mac (
        .CLK   (CLK),
        .RST_n (RST_n),
        .clr   (accept),
        .en    (in_mac),
        .last  (last),
        .xin   (x[k]),
        .hin   (h[k]),
        .dout  (DOUT)
    );

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb_fir_seq_ctrl: scoreboard bench for fir_seq_ctrl (DATA_WIDTH=13, TAPS=8)
module tb_fir_seq_ctrl;

    localparam int DW   = 13;
    localparam int TAPS = 8;

    logic                 CLK = 1'b0;
    logic                 RST_n;
    logic signed [DW-1:0] DIN;
    logic                 DIN_VALID;
    logic                 DIN_READY;
    logic                 COEF_WE;
    logic [2:0]           COEF_ADDR;
    logic signed [DW-1:0] COEF_DATA;
    logic                 FLUSH;
    logic signed [DW-1:0] DOUT;
    logic                 DOUT_VALID;
    logic                 DOUT_READY;
    logic                 BUSY;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t0;
    int got;
    int lat;
    bit got_ok;
    int exp_q[$];

    fir_seq_ctrl #(
        .DATA_WIDTH (DW),
        .TAPS       (TAPS)
    ) dut (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .DIN        (DIN),
        .DIN_VALID  (DIN_VALID),
        .DIN_READY  (DIN_READY),
        .COEF_WE    (COEF_WE),
        .COEF_ADDR  (COEF_ADDR),
        .COEF_DATA  (COEF_DATA),
        .FLUSH      (FLUSH),
        .DOUT       (DOUT),
        .DOUT_VALID (DOUT_VALID),
        .DOUT_READY (DOUT_READY),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    // Edge counter used to measure acceptance-to-valid latency
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic write_coef(input int a, input int v);
        @(negedge CLK);
        COEF_WE = 1'b1; COEF_ADDR = 3'(a); COEF_DATA = DW'(v);
        @(negedge CLK);
        COEF_WE = 1'b0;
    endtask

    task automatic do_flush();
        @(negedge CLK);
        FLUSH = 1'b1;
        @(negedge CLK);
        FLUSH = 1'b0;
    endtask

    task automatic start_sample(input int d, input int e);
        int n = 0;
        @(negedge CLK);
        while (!DIN_READY && n < 100) begin @(negedge CLK); n++; end
        exp_q.push_back(e);
        DIN = DW'(d); DIN_VALID = 1'b1;
        @(posedge CLK); #1;
        t0 = cyc; DIN_VALID = 1'b0;
    endtask

    task automatic wait_result();
        int n = 0;
        got_ok = 1'b0;
        while (n < 50) begin
            @(negedge CLK);
            if (DOUT_VALID) begin got_ok = 1'b1; break; end
            n++;
        end
        got = DOUT;
        lat = cyc - t0;
    endtask

    task automatic ack();
        DOUT_READY = 1'b1;
        @(negedge CLK);
        DOUT_READY = 1'b0;
    endtask

    task automatic run_impulse(input string tag);
        int e;
        for (int i = 0; i < TAPS; i++) begin
            start_sample(i == 0 ? 2048 : 0, 50 * i);
            wait_result();
            e = exp_q.pop_front();
            checks++;
            if (!got_ok || got !== e) begin
                errors++; $display("FAIL %s[%0d] dout got %0d want %0d (valid %0d)", tag, i, got, e, got_ok);
            end
            checks++;
            if (lat !== TAPS) begin
                errors++; $display("FAIL %s[%0d] latency got %0d want %0d", tag, i, lat, TAPS);
            end
            ack();
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK);
        checks++; if (DOUT !== 0)        begin errors++; $display("FAIL reset dout got %0d want 0", DOUT); end
        checks++; if (DOUT_VALID !== 0)  begin errors++; $display("FAIL reset dout_valid got %0b want 0", DOUT_VALID); end
        checks++; if (BUSY !== 0)        begin errors++; $display("FAIL reset busy got %0b want 0", BUSY); end
        checks++; if (DIN_READY !== 1)   begin errors++; $display("FAIL reset din_ready got %0b want 1", DIN_READY); end
        RST_n = 1'b1;
    endtask

    task automatic test_impulse();
        for (int i = 0; i < TAPS; i++) write_coef(i, 100 * i);
        run_impulse("impulse");
    endtask

    task automatic test_single_tap();
        int e;
        write_coef(0, 2048);
        for (int i = 1; i < TAPS; i++) write_coef(i, 0);
        start_sample(1000, 500);
        wait_result(); e = exp_q.pop_front();
        checks++; if (!got_ok || got !== e) begin errors++; $display("FAIL single_pos dout got %0d want %0d", got, e); end
        ack();
        start_sample(-1000, -500);
        wait_result(); e = exp_q.pop_front();
        checks++; if (!got_ok || got !== e) begin errors++; $display("FAIL single_neg dout got %0d want %0d", got, e); end
        ack();
    endtask

    task automatic test_saturation();
        int e;
        for (int i = 0; i < TAPS; i++) write_coef(i, 4095);
        do_flush();
        for (int i = 0; i < TAPS; i++) begin
            start_sample(4095, i == 0 ? 4094 : 4095);
            wait_result(); e = exp_q.pop_front();
            checks++; if (!got_ok || got !== e) begin errors++; $display("FAIL sat_pos[%0d] dout got %0d want %0d", i, got, e); end
            ack();
        end
        do_flush();
        for (int i = 0; i < TAPS; i++) begin
            start_sample(-4096, i == 0 ? -4095 : -4096);
            wait_result(); e = exp_q.pop_front();
            checks++; if (!got_ok || got !== e) begin errors++; $display("FAIL sat_neg[%0d] dout got %0d want %0d", i, got, e); end
            ack();
        end
    endtask

    task automatic test_backpressure();
        int e;
        write_coef(0, 2048);
        for (int i = 1; i < TAPS; i++) write_coef(i, 0);
        start_sample(1000, 500);
        wait_result(); e = exp_q.pop_front();
        checks++; if (!got_ok || got !== e) begin errors++; $display("FAIL bp_first dout got %0d want %0d", got, e); end
        COEF_WE = 1'b1; COEF_ADDR = 3'd0; COEF_DATA = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            checks++; if (DOUT_VALID !== 1) begin errors++; $display("FAIL bp_hold[%0d] dout_valid got %0b want 1", c, DOUT_VALID); end
            checks++; if (DOUT !== 500)     begin errors++; $display("FAIL bp_hold[%0d] dout got %0d want 500", c, DOUT); end
            checks++; if (DIN_READY !== 0)  begin errors++; $display("FAIL bp_hold[%0d] din_ready got %0b want 0", c, DIN_READY); end
        end
        COEF_WE = 1'b0;
        ack();
        checks++; if (DOUT_VALID !== 0) begin errors++; $display("FAIL bp_after dout_valid got %0b want 0", DOUT_VALID); end
        checks++; if (DOUT !== 500)     begin errors++; $display("FAIL bp_after dout got %0d want 500", DOUT); end
        start_sample(600, 300);
        wait_result(); e = exp_q.pop_front();
        checks++; if (!got_ok || got !== e) begin errors++; $display("FAIL bp_coef_kept dout got %0d want %0d", got, e); end
        ack();
    endtask

    task automatic test_flush();
        int e;
        write_coef(0, 0);
        for (int i = 1; i < TAPS; i++) write_coef(i, 2048);
        do_flush();
        start_sample(1000, 0);
        wait_result(); e = exp_q.pop_front();
        checks++; if (!got_ok || got !== e) begin errors++; $display("FAIL flush_pre dout got %0d want %0d", got, e); end
        ack();
        @(negedge CLK);
        FLUSH = 1'b1; DIN_VALID = 1'b1; DIN = 13'sd777;
        COEF_WE = 1'b1; COEF_ADDR = 3'd0; COEF_DATA = 13'sd2048;
        #1;
        checks++; if (DIN_READY !== 0) begin errors++; $display("FAIL flush_ready got %0b want 0", DIN_READY); end
        @(negedge CLK);
        FLUSH = 1'b0; DIN_VALID = 1'b0; COEF_WE = 1'b0;
        checks++; if (BUSY !== 0) begin errors++; $display("FAIL flush_not_accepted busy got %0b want 0", BUSY); end
        start_sample(2048, 1024);
        wait_result(); e = exp_q.pop_front();
        checks++; if (!got_ok || got !== e) begin errors++; $display("FAIL flush_post dout got %0d want %0d", got, e); end
        ack();
    endtask

    task automatic test_reset_mid_mac();
        for (int i = 0; i < TAPS; i++) write_coef(i, 100 * i);
        start_sample(2048, 0);
        repeat (4) @(negedge CLK);
        RST_n = 1'b0;
        #1;
        exp_q.delete();
        checks++; if (DOUT !== 0)       begin errors++; $display("FAIL rst_mid dout got %0d want 0", DOUT); end
        checks++; if (DOUT_VALID !== 0) begin errors++; $display("FAIL rst_mid dout_valid got %0b want 0", DOUT_VALID); end
        checks++; if (BUSY !== 0)       begin errors++; $display("FAIL rst_mid busy got %0b want 0", BUSY); end
        @(negedge CLK);
        RST_n = 1'b1;
        for (int i = 0; i < TAPS; i++) write_coef(i, 100 * i);
        run_impulse("impulse_after_rst");
    endtask

    initial begin
        RST_n = 1'b0; DIN = '0; DIN_VALID = 1'b0; COEF_WE = 1'b0; COEF_ADDR = '0;
        COEF_DATA = '0; FLUSH = 1'b0; DOUT_READY = 1'b0;
        test_reset();
        test_impulse();
        test_single_tap();
        test_saturation();
        test_backpressure();
        test_flush();
        test_reset_mid_mac();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
